// File: rtl/cordic_pkg.sv
// Shared definitions for the 16-bit CORDIC rotator pipeline.
//   IN_W / OUT_W  : input component width and widened pipeline width (signed).
//   ANG_FRAC      : fractional bits of every angle (Q2.15 radians in 18 bits).
//   PI_4 .. T5    : quadrant constants in Q2.15 (T3 = 3*pi/4, T5 = 5*pi/4).
//   angle_t       : 18-bit signed pipeline word (angles and vector components).
//   quad_t        : signed quarter-turn count, -3 .. +3.
package cordic_pkg;

  localparam int IN_W     = 16;
  localparam int OUT_W    = 18;
  localparam int ANG_FRAC = 15;

  localparam int PI_4  = 25736;
  localparam int PI_2  = 51472;
  localparam int PI    = 102944;
  localparam int PI3_2 = 154416;
  localparam int T3    = 77208;
  localparam int T5    = 128680;

  typedef logic signed [OUT_W-1:0] angle_t;
  typedef logic signed [2:0]       quad_t;

  // Sign-extend an input-width value to the pipeline width.
  function automatic angle_t sext_in(input logic signed [IN_W-1:0] v);
    return angle_t'(v);
  endfunction

endpackage

// File: rtl/cordic_stage0_if.sv
// Data bus of CORDIC stage 0: input sample (in_valid, Xin, Yin, Zin, theta)
// and registered result (out_valid, Xout, Yout, Zout).
// The DUT side uses modport slave, the producer/consumer uses master.
// Optional: CORDIC_STAGE0_QUAD_EN adds the 3-bit signed quarter-turn output quad.
interface cordic_stage0_if;
  import cordic_pkg::*;

  logic                   in_valid;
  logic signed [IN_W-1:0] Xin;
  logic signed [IN_W-1:0] Yin;
  logic signed [IN_W-1:0] Zin;
  angle_t                 theta;
  logic                   out_valid;
  angle_t                 Xout;
  angle_t                 Yout;
  angle_t                 Zout;
`ifdef CORDIC_STAGE0_QUAD_EN
  quad_t                  quad;

  modport master (output in_valid, Xin, Yin, Zin, theta,
                  input  out_valid, Xout, Yout, Zout, quad);
  modport slave  (input  in_valid, Xin, Yin, Zin, theta,
                  output out_valid, Xout, Yout, Zout, quad);
`else
  modport master (output in_valid, Xin, Yin, Zin, theta,
                  input  out_valid, Xout, Yout, Zout);
  modport slave  (input  in_valid, Xin, Yin, Zin, theta,
                  output out_valid, Xout, Yout, Zout);
`endif

endinterface

// File: rtl/cordic_quadrant_sel.sv
// Combinational quarter-turn selector.
//   r    : 19-bit signed residual angle theta - Zin (Q2.15).
//   k    : quarter-turn count so that r - k*pi/2 lies in [-pi/4, pi/4].
//   corr : k*pi/2 in Q2.15, 19-bit signed.
// Comparisons are strict, so a residual exactly on a threshold stays in the
// lower-magnitude band.
module cordic_quadrant_sel
  import cordic_pkg::*;
(
  input  logic signed [18:0] r,
  output quad_t              k,
  output logic signed [18:0] corr
);

  localparam logic signed [18:0] C1 = 19'(PI_2);
  localparam logic signed [18:0] C2 = 19'(PI);
  localparam logic signed [18:0] C3 = 19'(PI3_2);

  int r_i;
  assign r_i = int'(r);

  // NOTE: every output gets a default first so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    k    = 3'sd0;
    corr = '0;
    if (r_i > T5) begin
      k = 3'sd3;    corr = C3;
    end else if (r_i > T3) begin
      k = 3'sd2;    corr = C2;
    end else if (r_i > PI_4) begin
      k = 3'sd1;    corr = C1;
    end else if (r_i < -T5) begin
      k = -3'sd3;   corr = -C3;
    end else if (r_i < -T3) begin
      k = -3'sd2;   corr = -C2;
    end else if (r_i < -PI_4) begin
      k = -3'sd1;   corr = -C1;
    end
  end

endmodule

// File: rtl/cordic_stage0.sv
// CORDIC stage 0: quadrant pre-rotation by k*90 degrees, one-cycle latency.
//   clk : rising-edge clock.
//   rst : synchronous active-high reset (clears valid and data, wins over in_valid).
//   bus : cordic_stage0_if.slave -- in_valid/Xin/Yin/Zin/theta in,
//         out_valid/Xout/Yout/Zout out (18-bit signed, Zout residual in Q2.15).
// Optional: CORDIC_STAGE0_QUAD_EN exposes the registered k on bus.quad.
// Data registers load only on in_valid; out_valid follows in_valid by a cycle.
module cordic_stage0
  import cordic_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  cordic_stage0_if.slave  bus
);

  angle_t             x, y, x_rot, y_rot, z_res;
  logic signed [18:0] r, corr;
  quad_t              k;

  assign x = sext_in(bus.Xin);
  assign y = sext_in(bus.Yin);

  // 19 bits hold the full theta - Zin range without overflow.
  assign r = 19'(bus.theta) - 19'(bus.Zin);

  cordic_quadrant_sel u_sel (
    .r    (r),
    .k    (k),
    .corr (corr)
  );

  // The corrected residual is within +-pi/4, so dropping bit 18 is lossless.
  assign z_res = angle_t'(r - corr);

  // Negation happens at 18 bits, so -(-32768) is represented exactly.
  always_comb begin
    x_rot = x;
    y_rot = y;
    case (k)
      3'sd1, -3'sd3: begin x_rot = -y; y_rot = x;  end
      3'sd2, -3'sd2: begin x_rot = -x; y_rot = -y; end
      -3'sd1, 3'sd3: begin x_rot = y;  y_rot = -x; end
      default:       begin x_rot = x;  y_rot = y;  end
    endcase
  end

  // NOTE: registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.out_valid <= 1'b0;
      bus.Xout      <= '0;
      bus.Yout      <= '0;
      bus.Zout      <= '0;
`ifdef CORDIC_STAGE0_QUAD_EN
      bus.quad      <= '0;
`endif
    end else begin
      bus.out_valid <= bus.in_valid;
      if (bus.in_valid) begin
        bus.Xout <= x_rot;
        bus.Yout <= y_rot;
        bus.Zout <= z_res;
`ifdef CORDIC_STAGE0_QUAD_EN
        bus.quad <= k;
`endif
      end
    end
  end

endmodule

// File: tb/tb_cordic_stage0.sv
// Self-checking bench for cordic_stage0: directed plan vectors plus random
// samples, compared against an arithmetic reference model of the quadrant rules.
module tb_cordic_stage0;
  import cordic_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cordic_stage0_if bus ();

  cordic_stage0 dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference output state.
  int m_valid = 0, m_x = 0, m_y = 0, m_z = 0, m_k = 0;

  task automatic check(input string tag, input int observed, input int expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  function automatic int quarter(input int r);
    if (r > T5)          return 3;
    else if (r > T3)     return 2;
    else if (r > PI_4)   return 1;
    else if (r < -T5)    return -3;
    else if (r < -T3)    return -2;
    else if (r < -PI_4)  return -1;
    return 0;
  endfunction

  // Apply one sample for one clock, update the model, compare all outputs.
  task automatic step(input string tag, input bit v, input int xi, input int yi,
                      input int zi, input int th);
    int r, k, nx, ny;
    bus.in_valid = v;
    bus.Xin      = 16'(xi);
    bus.Yin      = 16'(yi);
    bus.Zin      = 16'(zi);
    bus.theta    = 18'(th);
    @(posedge clk);
    #1;
    if (rst) begin
      m_valid = 0; m_x = 0; m_y = 0; m_z = 0; m_k = 0;
    end else begin
      m_valid = v ? 1 : 0;
      if (v) begin
        // Wrap the stimulus ints to the port widths the DUT actually saw.
        xi = int'($signed(16'(xi)));
        yi = int'($signed(16'(yi)));
        zi = int'($signed(16'(zi)));
        th = int'($signed(18'(th)));
        r  = th - zi;
        k  = quarter(r);
        case (k)
          1, -3:   begin nx = -yi; ny = xi;  end
          2, -2:   begin nx = -xi; ny = -yi; end
          -1, 3:   begin nx = yi;  ny = -xi; end
          default: begin nx = xi;  ny = yi;  end
        endcase
        m_x = nx; m_y = ny; m_z = r - k * PI_2; m_k = k;
      end
    end
    check({tag, "_valid"}, int'(bus.out_valid), m_valid);
    check({tag, "_x"}, int'(bus.Xout), m_x);
    check({tag, "_y"}, int'(bus.Yout), m_y);
    check({tag, "_z"}, int'(bus.Zout), m_z);
`ifdef CORDIC_STAGE0_QUAD_EN
    check({tag, "_quad"}, int'(bus.quad), m_k);
`endif
  endtask

  task automatic expect_out(input string tag, input int ex, input int ey, input int ez);
    check({tag, "_cx"}, int'(bus.Xout), ex);
    check({tag, "_cy"}, int'(bus.Yout), ey);
    check({tag, "_cz"}, int'(bus.Zout), ez);
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.Xin = '0; bus.Yin = '0; bus.Zin = '0; bus.theta = '0;

    // Reset state.
    step("rst", 1'b1, 11, 22, 0, 0);
    step("rst2", 1'b0, 0, 0, 0, 0);
    rst = 1'b0;

    // Plan vectors with hand-derived expectations as well as the model.
    step("npi", 1'b1, 19429, 0, 0, 102943);
    expect_out("npi", -19429, 0, -1);
    step("p90", 1'b1, 1000, 0, 0, 51472);
    expect_out("p90", 0, 1000, 0);
    step("m90", 1'b1, 1000, 0, 0, -51472);
    expect_out("m90", 0, -1000, 0);
    step("thr", 1'b1, 5, 7, 0, 25736);
    expect_out("thr", 5, 7, 25736);
    step("thr1", 1'b1, 5, 7, 0, 25737);
    expect_out("thr1", -7, 5, -25735);
    step("ext", 1'b1, 100, 200, -32768, 131071);
    expect_out("ext", 200, -100, 9423);
    step("neg", 1'b1, -32768, 0, 0, 102944);
    check("neg_cx", int'(bus.Xout), 32768);

    // Other exact thresholds on the negative side and at 3pi/4, 5pi/4.
    step("t3", 1'b1, 3, -4, 0, 77208);
    step("t3p", 1'b1, 3, -4, 0, 77209);
    step("t5", 1'b1, 3, -4, 0, 128680);
    step("t5p", 1'b1, 3, -4, 0, 128681);
    step("nt3", 1'b1, 3, -4, 0, -77208);
    step("nt3p", 1'b1, 3, -4, 0, -77209);
    step("nt5", 1'b1, 3, -4, 0, -128680);
    step("nt5p", 1'b1, 3, -4, 0, -128681);
    step("npi4", 1'b1, 3, -4, 0, -25737);
    step("rmin", 1'b1, 9, 9, 32767, -131072);

    // Hold: outputs stay while in_valid is low, with garbage on the inputs.
    step("ld", 1'b1, 1234, -567, 100, 60000);
    for (int i = 0; i < 3; i++) step("hold", 1'b0, 999, 888, 777, -99999);
    expect_out("hold", 567, 1234, 60000 - 100 - PI_2);

    // Reset mid-stream with in_valid high.
    step("pre", 1'b1, 42, 43, 0, 1000);
    rst = 1'b1;
    step("mrst", 1'b1, 42, 43, 0, 1000);
    expect_out("mrst", 0, 0, 0);
    rst = 1'b0;

    // Random back-to-back and gapped traffic.
    for (int i = 0; i < 400; i++) begin
      step("rnd", ($urandom_range(0, 3) != 0), int'($urandom), int'($urandom),
           int'($urandom), int'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cordic_stage0.md
Name: cordic_stage0

Overview:
- First pipeline stage of the team's 16-bit CORDIC rotator.
- Takes a 16-bit signed vector (Xin, Yin), a 16-bit angle-accumulator offset Zin and an 18-bit target angle theta.
- Performs quadrant pre-rotation by a multiple of 90°, so the residual angle handed to the micro-rotation stages lies in [-π/4, π/4].
- Registered, one-cycle latency; outputs are widened to 18 bits for the downstream stages.

Parameters:
- IN_W, 16, width of Xin/Yin/Zin (signed).
- OUT_W, 18, width of theta, Xout/Yout/Zout (signed).
- ANG_FRAC, 15, fractional bits of all angles (radians, Q2.15 in 18 bits).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous active-high reset.
- in_valid  in  1  input sample valid.
- Xin  in  16  signed X component.
- Yin  in  16  signed Y component.
- Zin  in  16  signed angle already accounted for, sign-extended to Q2.15.
- theta  in  18  signed target angle, Q2.15 radians.
- out_valid  out  1  output sample valid.
- Xout  out  18  signed pre-rotated X.
- Yout  out  18  signed pre-rotated Y.
- Zout  out  18  signed residual angle, Q2.15.

Behaviour:
- Reset and clocking:
  - One clock; reset is synchronous and active-high.
  - On a clk edge with rst=1: out_valid=0, Xout=Yout=Zout=0. Reset wins over in_valid.
- Latency and handshake:
  - Latency is 1 cycle and there is no backpressure.
  - out_valid is in_valid delayed by one cycle.
  - Data registers load only when in_valid=1 and hold otherwise.
- Residual angle:
  - r = theta − sext(Zin), computed in 19 bits. Range is [-163839, 163839], so no overflow.
- Constants: PI_4=25736, PI_2=51472, PI=102944, PI3_2=154416, T3=77208 (3π/4), T5=128680 (5π/4).
- Quarter-turn count k, first match wins, all comparisons strict:
  - r > T5 → k=+3.
  - r > T3 → +2.
  - r > PI_4 → +1.
  - r < −T5 → −3.
  - r < −T3 → −2.
  - r < −PI_4 → −1.
  - otherwise k=0.
  - An r exactly equal to a threshold stays in the lower-magnitude band.
- Vector mapping, with x = sext18(Xin) and y = sext18(Yin):
  - k=0 → (x, y).
  - k=+1 or −3 → (−y, x).
  - k=±2 → (−x, −y).
  - k=−1 or +3 → (y, −x).
- Zout = r − k·PI_2, using the constants above. The result is always in [-25736, 25736] and fits 18 bits.
- Negation is done in 18 bits, so −(−32768) = 32768 is exact. No saturation is needed.
- No gain compensation in this stage; magnitude is preserved exactly.

Optional Feature:
- Macro CORDIC_STAGE0_QUAD_EN.
- When defined: an extra output port quad (3-bit signed) carries the registered k for the same sample as Xout. It resets to 0 and loads with the data registers.
- When undefined: the port and its register are absent. All other behaviour is identical.

Decomposition:
- Package cordic_pkg holds:
  - IN_W, OUT_W and ANG_FRAC;
  - the angle constants PI_4, PI_2, PI, PI3_2, T3 and T5;
  - typedef angle_t (signed [17:0]) and typedef quad_t (signed [2:0]).
- One combinational sub-module, cordic_quadrant_sel: input r, outputs k and the k·PI_2 correction.
- The top level does sign extension, the vector mux and the registers.

Test Plan:
- Reset: assert rst mid-stream with in_valid=1 → next cycle out_valid=0, Xout=Yout=Zout=0.
- Near-π: Xin=19429, Yin=0, Zin=0, theta=102943, in_valid=1 → after 1 cycle, k=+2, Xout=−19429, Yout=0, Zout=−1, out_valid=1.
- +90°: Xin=1000, Yin=0, Zin=0, theta=51472 → Xout=0, Yout=1000, Zout=0. −90° case: theta=−51472 → Xout=0, Yout=−1000, Zout=0.
- Threshold boundary:
  - theta=25736, Zin=0, X=5, Y=7 → k=0, Xout=5, Yout=7, Zout=25736.
  - theta=25737 → k=+1, Xout=−7, Yout=5, Zout=−25735.
- Extremes:
  - theta=131071, Zin=−32768, Xin=100, Yin=200 → r=163839, k=+3, Xout=200, Yout=−100, Zout=9423.
  - Xin=−32768, Yin=0, theta=102944 → Xout=32768.
- Hold and valid: in_valid=0 for 3 cycles after a valid sample → out_valid=0, data outputs unchanged. Back-to-back valid samples → one result per cycle in order.
